delay_and_sum: RTL and testbench

DELAY_AND_SUM -- requirements
Module: delay_and_sum

---
 rtl/delay_and_sum_if.sv | 33 +++
 rtl/delay_and_sum.sv | 123 ++++++++++++
 tb/tb_delay_and_sum.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/delay_and_sum_if.sv
// Sample-stream bundle for the two-channel delay-and-sum beamformer.
// The master drives samples and steering controls; the slave returns beams.
interface delay_and_sum_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_left;
  logic signed [DATA_WIDTH-1:0] in_right;
  logic [AW-1:0]                delay_left;
  logic [AW-1:0]                delay_right;
  logic                         delay_load;
  logic                         avg_mode;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_sat;

  modport master (
    output in_valid, in_left, in_right,
    output delay_left, delay_right, delay_load,
    output avg_mode,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_left, in_right,
    input  delay_left, delay_right, delay_load,
    input  avg_mode,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/delay_and_sum.sv
// Two-channel delay-and-sum beamformer: circular histories, steerable
// per-channel delay, saturating sum or average, FILL/RUN output gating.
module delay_and_sum #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input logic            clk,
  input logic            reset,
  delay_and_sum_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {FILL, RUN} state_t;

  state_t state, state_d;

  logic signed [DW-1:0] mem_l [DEPTH];
  logic signed [DW-1:0] mem_r [DEPTH];

  logic [AW-1:0] wptr, dl, dr, dmax;
  logic [AW-1:0] s1_addr, s1_dl, s1_dr;
  logic [AW-1:0] ridx_l, ridx_r;
  logic [CW-1:0] fcnt, fcnt_d;
  logic          tick, emit;

  logic signed [DW-1:0] rd_l, rd_r;
  logic signed [DW:0]   sum;
  logic [DW-1:0]        res;
  logic                 sat;

  assign dmax = (dl > dr) ? dl : dr;

  always_comb begin
    fcnt_d  = fcnt;
    state_d = state;
    emit    = 1'b0;
    if (bus.in_valid && fcnt != CW'(DEPTH))
      fcnt_d = fcnt + 1'b1;
    unique case (state)
      FILL: begin
        // Count includes the current write: gate until the read is covered
        if (bus.in_valid && fcnt_d > {1'b0, dmax}) begin
          state_d = RUN;
          emit    = 1'b1;
        end
      end
      RUN: emit = bus.in_valid;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      fcnt    <= '0;
      dl      <= '0;
      dr      <= '0;
      tick    <= 1'b0;
      s1_addr <= '0;
      s1_dl   <= '0;
      s1_dr   <= '0;
    end else begin
      fcnt <= fcnt_d;
      tick <= emit;
      if (bus.in_valid) begin
        wptr    <= wptr + 1'b1;
        s1_addr <= wptr;
        s1_dl   <= dl;
        s1_dr   <= dr;
      end
      if (bus.delay_load) begin
        dl <= bus.delay_left;
        dr <= bus.delay_right;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.in_valid) begin
      mem_l[wptr] <= bus.in_left;
      mem_r[wptr] <= bus.in_right;
    end
  end

  assign ridx_l = s1_addr - s1_dl;
  assign ridx_r = s1_addr - s1_dr;
  assign rd_l   = mem_l[ridx_l];
  assign rd_r   = mem_r[ridx_r];
  assign sum    = {rd_l[DW-1], rd_l} + {rd_r[DW-1], rd_r};

  always_comb begin
    res = sum[DW-1:0];
    sat = 1'b0;
    if (bus.avg_mode) begin
      res = sum[DW:1];
    end else if (sum[DW] != sum[DW-1]) begin
      sat = 1'b1;
      res = sum[DW] ? SMIN : SMAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      bus.out_valid <= tick;
      if (tick) begin
        bus.out_data <= res;
        bus.out_sat  <= sat;
      end
    end
  end
endmodule

// File: tb/tb_delay_and_sum.sv
// Bench for delay_and_sum: sample-list reference model checked every cycle
// plus hand-computed literal expectations on directed vectors.
module tb_delay_and_sum;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  delay_and_sum_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  delay_and_sum #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int hl[$];
  int hr[$];
  int mdl, mdr, fcnt;
  bit run, pend, pdc;
  int pl, pr;

  bit armed     = 1'b0;
  bit exp_valid = 1'b0;
  int exp_data  = 0;
  bit exp_sat   = 1'b0;
  bit exp_dc    = 1'b0;

  task automatic chk(input string name, input integer act, input integer exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the reference from the inputs now applied,
  // then publish what must be visible after the edge.
  task automatic step();
    bit nv  = 1'b0;
    int nd  = exp_data;
    bit ns  = exp_sat;
    bit ndc = exp_dc;
    int s, k, m;
    if (reset) begin
      nd = 0; ns = 0; ndc = 0;
      pend = 0; run = 0; fcnt = 0; mdl = 0; mdr = 0;
      hl.delete(); hr.delete();
    end else begin
      if (pend) begin
        nv  = 1'b1;
        ndc = pdc;
        s   = pl + pr;
        if (bus.avg_mode) begin
          nd = s >>> 1; ns = 0;
        end else if (s > 127) begin
          nd = 127; ns = 1;
        end else if (s < -128) begin
          nd = -128; ns = 1;
        end else begin
          nd = s; ns = 0;
        end
      end
      pend = 0;
      if (bus.in_valid) begin
        hl.push_back(int'($signed(bus.in_left)));
        hr.push_back(int'($signed(bus.in_right)));
        if (fcnt < DEPTH) fcnt++;
        m = (mdl > mdr) ? mdl : mdr;
        if (run || fcnt > m) begin
          run  = 1;
          pend = 1;
          k    = hl.size() - 1;
          pdc  = (k - mdl < 0) || (k - mdr < 0);
          pl   = pdc ? 0 : hl[k - mdl];
          pr   = pdc ? 0 : hr[k - mdr];
        end
      end
      if (bus.delay_load) begin
        mdl = int'(bus.delay_left);
        mdr = int'(bus.delay_right);
      end
    end
    @(posedge clk);
    #1;
    exp_valid = nv;
    exp_data  = nd;
    exp_sat   = ns;
    exp_dc    = ndc;
    armed     = 1'b1;
    bus.in_valid   = 1'b0;
    bus.delay_load = 1'b0;
  endtask

  task automatic sample(input int l, input int r);
    bus.in_valid = 1'b1;
    bus.in_left  = DW'(l);
    bus.in_right = DW'(r);
    step();
  endtask

  task automatic load(input int l, input int r);
    bus.delay_load  = 1'b1;
    bus.delay_left  = AW'(l);
    bus.delay_right = AW'(r);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", bus.out_valid, exp_valid);
      if (!exp_dc) begin
        chk("out_data", $signed(bus.out_data), exp_data);
        chk("out_sat", bus.out_sat, exp_sat);
      end
    end
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_left     = '0;
    bus.in_right    = '0;
    bus.delay_left  = '0;
    bus.delay_right = '0;
    bus.delay_load  = 1'b0;
    bus.avg_mode    = 1'b0;

    reset = 1'b1;
    step();
    load(5, 5);
    step();
    reset = 1'b0;
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_data", $signed(bus.out_data), 0);

    sample(10, 20);
    chk("lat_not_early", bus.out_valid, 0);
    step();
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_sum", $signed(bus.out_data), 30);
    chk("basic_sat", bus.out_sat, 0);
    step();
    chk("single_strobe", bus.out_valid, 0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    load(3, 0);
    step();
    for (int i = 1; i <= 5; i++) begin
      sample(i, 0);
      if (i == 4) chk("fill_gate3", bus.out_valid, 0);
      if (i == 5) chk("fill_s4", $signed(bus.out_data), 1);
    end
    step();
    chk("fill_s5", $signed(bus.out_data), 2);
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;
    sample(100, 100);
    sample(-100, -100);
    chk("sat_pos", $signed(bus.out_data), 127);
    chk("sat_pos_flag", bus.out_sat, 1);
    step();
    chk("sat_neg", $signed(bus.out_data), -128);
    chk("sat_neg_flag", bus.out_sat, 1);
    step();
    chk("hold_data", $signed(bus.out_data), -128);

    bus.avg_mode = 1'b1;
    sample(127, 127);
    sample(-3, 0);
    chk("avg_max", $signed(bus.out_data), 127);
    chk("avg_max_sat", bus.out_sat, 0);
    step();
    chk("avg_floor", $signed(bus.out_data), -2);
    bus.avg_mode = 1'b0;

    load(1, 0);
    sample(50, 0);
    sample(60, 0);
    chk("coincident_old", $signed(bus.out_data), 50);
    step();
    chk("coincident_new", $signed(bus.out_data), 50);
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;
    load(15, 0);
    step();
    for (int i = 0; i < 40; i++) sample(i, 0);
    chk("wrap_s38", $signed(bus.out_data), 38 - 15);
    step();
    chk("wrap_s39", $signed(bus.out_data), 39 - 15);
    step();

    sample(5, 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("cancel_valid", bus.out_valid, 0);
    step();
    chk("cancel_late", bus.out_valid, 0);
    load(2, 0);
    step();
    sample(11, 1);
    sample(12, 2);
    sample(13, 3);
    chk("refill_gated", bus.out_valid, 0);
    step();
    chk("refill_first", $signed(bus.out_data), 11 + 3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
